// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyb_tapcal_pkg.sv
// Shared definitions for the dlyb tap-select calibration sequencer:
// FSM state encoding, the minimum settle time and the tap-width helper.
package gf180mcu_fd_sc_mcu9t5v0__dlyb_tapcal_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        FIRE = 3'd2,
        WAIT = 3'd3,
        EVAL = 3'd4,
        LOCK = 3'd5
    } state_t;

    // Two synchroniser flops must have passed before CAPT is trusted.
    localparam int SETTLE_MIN = 2;

    // Width needed to index n values; never less than one bit.
    function automatic int tap_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyb_tapcal_sync.sv
// Two-flop synchroniser for the raw capture-flop output, cleared by RN.
module gf180mcu_fd_sc_mcu9t5v0__dlyb_tapcal_sync (
    input  logic CLK,
    input  logic RN,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the asynchronous input; both stages clear on reset.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyb_tapcal.sv
// Tap-select calibration sequencer for a dlyb delay line. Sweeps taps from
// 0 upward, launching one test edge per tap, and locks on the first tap
// whose edge misses the capture clock.
// Optional feature: define DLYB_TAPCAL_TRACK_EN for periodic background
// re-checks in LOCK that may lengthen the selected tap.
module gf180mcu_fd_sc_mcu9t5v0__dlyb_tapcal
    import gf180mcu_fd_sc_mcu9t5v0__dlyb_tapcal_pkg::*;
#(
    parameter int NTAPS        = 16,
    parameter int TW           = tap_width(NTAPS),
    parameter int SETTLE       = 3,
    parameter int TRACK_PERIOD = 1024
) (
    input  logic          CLK,
    input  logic          RN,
    input  logic          START,
    input  logic          CAPT,
    output logic          LAUNCH,
    output logic [TW-1:0] TAP_SEL,
    output logic          BUSY,
    output logic          DONE,
    output logic          LOCKED,
    output logic          ERR
);

    localparam int SETTLE_EFF = (SETTLE < SETTLE_MIN) ? SETTLE_MIN : SETTLE;
    localparam int WW         = tap_width(SETTLE_EFF);
    localparam logic [TW-1:0] TAP_MAX   = TW'(NTAPS - 1);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(SETTLE_EFF - 1);

    state_t          state_reg, state_next;
    logic [TW-1:0]   tap_reg, tap_next;
    logic [WW-1:0]   wait_reg, wait_next;
    logic            locked_reg, locked_next;
    logic            err_reg, err_next;
    logic            done_reg, done_next;
    logic            launch_reg, launch_next;
    logic            busy_reg, busy_next;
    logic            capt_s;
    logic            trk;
    logic            trk_start;

    gf180mcu_fd_sc_mcu9t5v0__dlyb_tapcal_sync u_sync (
        .CLK (CLK),
        .RN  (RN),
        .d   (CAPT),
        .q   (capt_s)
    );

`ifdef DLYB_TAPCAL_TRACK_EN
    localparam int TCW = tap_width(TRACK_PERIOD);
    localparam logic [TCW-1:0] TRACK_LAST = TCW'(TRACK_PERIOD - 1);

    logic [TCW-1:0] track_reg;
    logic           trk_reg, trk_next;

    assign trk       = trk_reg;
    assign trk_start = (state_reg == LOCK) && locked_reg && (track_reg == TRACK_LAST);

    // Period counter runs only while a valid tap is held; leaving LOCK restarts it.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            track_reg <= '0;
        end else if (state_reg != LOCK || !locked_reg || trk_start) begin
            track_reg <= '0;
        end else begin
            track_reg <= track_reg + 1'b1;
        end
    end

    // Remembers whether the current pass is a background re-check.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            trk_reg <= 1'b0;
        end else begin
            trk_reg <= trk_next;
        end
    end

    always_comb begin
        trk_next = trk_reg;
        if ((state_reg == IDLE || state_reg == LOCK) && START) begin
            trk_next = 1'b0;
        end else if (trk_start) begin
            trk_next = 1'b1;
        end
    end
`else
    assign trk       = 1'b0;
    assign trk_start = 1'b0;
`endif

    // State and registered outputs; LAUNCH/BUSY are decoded a cycle early so
    // the ports come straight from flops and cannot glitch into the macro.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_reg  <= IDLE;
            tap_reg    <= '0;
            wait_reg   <= '0;
            locked_reg <= 1'b0;
            err_reg    <= 1'b0;
            done_reg   <= 1'b0;
            launch_reg <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            tap_reg    <= tap_next;
            wait_reg   <= wait_next;
            locked_reg <= locked_next;
            err_reg    <= err_next;
            done_reg   <= done_next;
            launch_reg <= launch_next;
            busy_reg   <= busy_next;
        end
    end

    // Next-state and output decode for the sweep / tracking sequencer.
    always_comb begin
        state_next  = state_reg;
        tap_next    = tap_reg;
        wait_next   = wait_reg;
        locked_next = locked_reg;
        err_next    = err_reg;
        done_next   = 1'b0;

        case (state_reg)
            IDLE, LOCK: begin
                if (START) begin
                    tap_next    = '0;
                    locked_next = 1'b0;
                    err_next    = 1'b0;
                    state_next  = ARM;
                end else if (trk_start) begin
                    state_next = ARM;
                end
            end
            ARM: state_next = FIRE;
            FIRE: begin
                wait_next  = WAIT_LOAD;
                state_next = WAIT;
            end
            WAIT: begin
                if (wait_reg == '0) begin
                    state_next = EVAL;
                end else begin
                    wait_next = wait_reg - 1'b1;
                end
            end
            EVAL: begin
                if (!capt_s) begin
                    // Edge missed the clock: this tap is long enough.
                    state_next = LOCK;
                    if (!trk) begin
                        locked_next = 1'b1;
                        done_next   = 1'b1;
                    end
                end else if (tap_reg != TAP_MAX) begin
                    tap_next   = tap_reg + 1'b1;
                    state_next = trk ? LOCK : ARM;
                end else begin
                    // Ran out of taps; the last tap stays selected.
                    err_next    = 1'b1;
                    locked_next = 1'b0;
                    done_next   = !trk;
                    state_next  = LOCK;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign launch_next = (state_next == FIRE);
    assign busy_next   = (state_next == ARM) || (state_next == FIRE) ||
                         (state_next == WAIT) || (state_next == EVAL);

    assign LAUNCH  = launch_reg;
    assign TAP_SEL = tap_reg;
    assign BUSY    = busy_reg;
    assign DONE    = done_reg;
    assign LOCKED  = locked_reg;
    assign ERR     = err_reg;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dlyb_tapcal.sv
// Directed bench for the dlyb tap calibration sequencer (NTAPS=16, SETTLE=3,
// so each tap takes 6 cycles). CAPT is modelled as "edge still captured"
// for every tap below lock_tap.
module tb_gf180mcu_fd_sc_mcu9t5v0__dlyb_tapcal;

    logic       CLK = 1'b0;
    logic       RN = 1'b0;
    logic       START = 1'b0;
    logic       CAPT;
    logic       LAUNCH;
    logic [3:0] TAP_SEL;
    logic       BUSY;
    logic       DONE;
    logic       LOCKED;
    logic       ERR;

    int checks = 0;
    int errors = 0;
    int lock_tap = 5;

    gf180mcu_fd_sc_mcu9t5v0__dlyb_tapcal #(
        .NTAPS        (16),
        .SETTLE       (3),
        .TRACK_PERIOD (32)
    ) dut (
        .CLK     (CLK),
        .RN      (RN),
        .START   (START),
        .CAPT    (CAPT),
        .LAUNCH  (LAUNCH),
        .TAP_SEL (TAP_SEL),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .LOCKED  (LOCKED),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    // Delay-line model: the edge is still captured while the tap is too short.
    always_comb CAPT = (int'(TAP_SEL) < lock_tap);

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse START at edge 0 and run until DONE; optionally re-pulse START at tap 2.
    task automatic run_cal(input int lk, input bit inject, output int done_edge,
                           output int launches, output int busy0);
        bit injected = 1'b0;
        lock_tap  = lk;
        done_edge = -1;
        launches  = 0;
        START = 1'b1;
        step();
        START = 1'b0;
        busy0 = int'(BUSY);
        for (int e = 1; e <= 200; e++) begin
            step();
            START = 1'b0;
            if (LAUNCH) launches++;
            if (DONE) begin
                done_edge = e;
                break;
            end
            if (inject && !injected && BUSY && TAP_SEL == 4'd2) begin
                START = 1'b1;
                injected = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        START = 1'b1;
        repeat (4) begin
            @(posedge CLK);
        end
        #1;
        chk("reset_outputs", {LAUNCH, TAP_SEL, BUSY, DONE, LOCKED, ERR}, 0);
        START = 1'b0;
        RN = 1'b1;
        step();
        // Start a sweep, then pull RN low while LAUNCH is high.
        lock_tap = 5;
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        chk("fire_launch_high", int'(LAUNCH), 1);
        #2 RN = 1'b0;
        #1;
        chk("reset_async_launch", int'(LAUNCH), 0);
        chk("reset_async_busy", int'(BUSY), 0);
        @(negedge CLK);
        RN = 1'b1;
        step();
        chk("reset_idle_after", {LAUNCH, TAP_SEL, BUSY, DONE, LOCKED, ERR}, 0);
    endtask

    task automatic test_lock5();
        int de, nl, b0;
        run_cal(5, 1'b0, de, nl, b0);
        chk("lock5_busy_after_start", b0, 1);
        chk("lock5_done_edge", de, 36);
        chk("lock5_tap", int'(TAP_SEL), 5);
        chk("lock5_locked", int'(LOCKED), 1);
        chk("lock5_err", int'(ERR), 0);
        chk("lock5_busy_at_done", int'(BUSY), 0);
        chk("lock5_launches", nl, 6);
        step();
        chk("lock5_done_one_cycle", int'(DONE), 0);
    endtask

    task automatic test_fail();
        int de, nl, b0;
        run_cal(16, 1'b0, de, nl, b0);
        chk("fail_done_edge", de, 96);
        chk("fail_tap", int'(TAP_SEL), 15);
        chk("fail_err", int'(ERR), 1);
        chk("fail_locked", int'(LOCKED), 0);
        chk("fail_launches", nl, 16);
    endtask

    task automatic test_immediate();
        int de, nl, b0;
        run_cal(0, 1'b0, de, nl, b0);
        chk("imm_done_edge", de, 6);
        chk("imm_tap", int'(TAP_SEL), 0);
        chk("imm_locked_err", {LOCKED, ERR}, 2);
        chk("imm_launches", nl, 1);
    endtask

    task automatic test_start_ignored();
        int de, nl, b0;
        run_cal(5, 1'b1, de, nl, b0);
        chk("ign_done_edge", de, 36);
        chk("ign_tap", int'(TAP_SEL), 5);
        chk("ign_launches", nl, 6);
        // Re-START from LOCK: the tap resets and a fresh sweep runs.
        lock_tap = 3;
        START = 1'b1;
        step();
        START = 1'b0;
        chk("restart_tap0", int'(TAP_SEL), 0);
        chk("restart_locked_clr", int'(LOCKED), 0);
        de = -1;
        for (int e = 1; e <= 100; e++) begin
            step();
            if (DONE) begin
                de = e;
                break;
            end
        end
        chk("restart_done_edge", de, 24);
        chk("restart_tap", int'(TAP_SEL), 3);
    endtask

`ifdef DLYB_TAPCAL_TRACK_EN
    task automatic test_tracking();
        int de, nl, b0;
        int dones = 0;
        int busy_seen = 0;
        run_cal(5, 1'b0, de, nl, b0);
        chk("trk_lock5", int'(TAP_SEL), 5);
        lock_tap = 6;
        for (int c = 0; c < 90; c++) begin
            step();
            if (DONE) dones++;
            if (BUSY) busy_seen++;
        end
        chk("trk_tap6", int'(TAP_SEL), 6);
        chk("trk_locked", int'(LOCKED), 1);
        chk("trk_no_done", dones, 0);
        chk("trk_busy_seen", int'(busy_seen > 0), 1);
        lock_tap = 16;
        for (int c = 0; c < 800 && !ERR; c++) begin
            step();
            if (DONE) dones++;
        end
        chk("trk_sat_err", int'(ERR), 1);
        chk("trk_sat_locked", int'(LOCKED), 0);
        chk("trk_sat_tap", int'(TAP_SEL), 15);
        chk("trk_sat_no_done", dones, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_lock5();
        test_fail();
        test_immediate();
        test_start_ignored();
`ifdef DLYB_TAPCAL_TRACK_EN
        test_tracking();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
